adc_spi_capture: RTL

- Upstream feeder of the CPU's `adcdata` input: SPI master (mode 0) for an external serial ADC such as an MCP3201-class 12-bit part.
- Launches conversions at a fixed sample rate, shifts in the result MSB-first, and presents it zero-extended to DWIDTH.
- Holds the last result on `adcdata` for the CPU and flags each new sample with a one-cycle `adcvalid` pulse.

---
 rtl/adc_pkg.sv | 26 ++
 rtl/adc_sample_timer.sv | 38 +++
 rtl/adc_spi_capture.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared types and elaboration helpers for the serial ADC capture block.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } adc_state_t;

  // SCLK periods per conversion frame: discarded lead bits plus kept result bits.
  function automatic int unsigned nbits(input int unsigned lead, input int unsigned samp);
    return lead + samp;
  endfunction

  // Cycles from the accepted start to the adcvalid cycle.
  function automatic int unsigned conv_cycles(input int unsigned clkdiv, input int unsigned nb);
    return clkdiv * (1 + 2 * nb) + 1;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adc_sample_timer.sv
// Free-running sample-rate timer; raises a start request whenever it sits at zero while enabled.
module adc_sample_timer
  import adc_pkg::*;
#(
  parameter int unsigned SAMPLEPERIOD = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic start_req
);

  localparam int unsigned TW = cnt_width(SAMPLEPERIOD);

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;

  // Count 0..SAMPLEPERIOD-1 while enabled, park at zero otherwise.
  always_comb begin
    timer_d = '0;
    if (enable) begin
      timer_d = (timer_q == TW'(SAMPLEPERIOD - 1)) ? '0 : timer_q + TW'(1);
    end
  end

  // Timer register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  // Request is live in the very first enabled cycle because the timer rests at zero.
  assign start_req = enable && (timer_q == '0);

endmodule

// File: rtl/adc_spi_capture.sv
// Mode-0 SPI master that periodically reads a serial ADC and presents the result to the CPU.
module adc_spi_capture
  import adc_pkg::*;
#(
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned SAMPLEBITS   = 12,
  parameter int unsigned LEADBITS     = 3,
  parameter int unsigned CLKDIV       = 4,
  parameter int unsigned SAMPLEPERIOD = 1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              adc_miso,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic [DWIDTH-1:0] adcdata,
  output logic              adcvalid,
  output logic              busy,
  output logic              missed
);

  localparam int unsigned NBITS = nbits(LEADBITS, SAMPLEBITS);
  localparam int unsigned DIVW  = cnt_width(CLKDIV);
  localparam int unsigned BITW  = cnt_width(NBITS);

  adc_state_t            state_q, state_d;
  logic [DIVW-1:0]       div_q, div_d;
  logic [BITW-1:0]       bit_q, bit_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_n_q, cs_n_d;
  logic [SAMPLEBITS-1:0] shift_q, shift_d;
  logic [DWIDTH-1:0]     data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  missed_q, missed_d;
  logic [1:0]            sync_q;
  logic                  miso_s;
  logic                  start_req;

  adc_sample_timer #(
    .SAMPLEPERIOD(SAMPLEPERIOD)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .start_req(start_req)
  );

  assign miso_s = sync_q[1];

  // Two-flop synchroniser for the ADC data line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], adc_miso};
    end
  end

  // Frame sequencing: chip-select setup, SCLK half-period divider, bit capture, result handoff.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    cs_n_d   = cs_n_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    missed_d = start_req && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        if (start_req) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end
      end

      SETUP: begin
        if (div_q == DIVW'(CLKDIV - 1)) begin
          state_d = SHIFT;
          div_d   = '0;
        end else begin
          div_d = div_q + DIVW'(1);
        end
      end

      SHIFT: begin
        if (div_q == DIVW'(CLKDIV - 1)) begin
          div_d = '0;
          if (!sclk_q) begin
            // Rising SCLK: capture; the oldest (lead) bits fall off the top.
            sclk_d  = 1'b1;
            shift_d = SAMPLEBITS'({shift_q, miso_s});
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BITW'(NBITS - 1)) begin
              state_d = DONE;
              cs_n_d  = 1'b1;
              data_d  = DWIDTH'(shift_q);
              valid_d = 1'b1;
            end else begin
              bit_d = bit_q + BITW'(1);
            end
          end
        end else begin
          div_d = div_q + DIVW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      missed_q <= missed_d;
    end
  end

  assign adc_cs_n = cs_n_q;
  assign adc_sclk = sclk_q;
  assign adcdata  = data_q;
  assign adcvalid = valid_q;
  assign busy     = busy_q;
  assign missed   = missed_q;

endmodule
